// File: rtl/demux_stream_ctrl_if.sv
// Valid/ready stream bundle for the packet demux: one source side and N output channels.
interface demux_stream_ctrl_if #(
   parameter int N  = 2,
   parameter int DW = 1,
   parameter int SW = 2
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic [SW-1:0] s_dest;
   logic          s_last;
   logic [N-1:0]  m_valid;
   logic [N-1:0]  m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;

   modport master (
      output s_valid, s_data, s_dest, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  s_valid, s_data, s_dest, s_last, m_ready,
      output s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/demux_stream_ctrl.sv
// Packet-level 1-to-N stream demux with a locked select and a one-entry output register.
// Optional per-channel delivered-packet counters: define DEMUX_STREAM_CTRL_CNT_EN.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet; select may change here only
// FWD   | mid-packet, beats go to the locked select
// DROP  | mid-packet to an invalid destination, beats are consumed and discarded
module demux_stream_ctrl #(
   parameter int N  = 2,
   parameter int DW = 1,
   parameter int SW = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   demux_stream_ctrl_if.slave   bus,
   output logic                 busy,
   output logic                 err_dest
`ifdef DEMUX_STREAM_CTRL_CNT_EN
   ,
   output logic [N*16-1:0]      pkt_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          full_q, full_d;
   logic [DW-1:0] data_q, data_d;
   logic          last_q, last_d;
   logic [SW-1:0] sel_q, sel_d;
   logic          err_q, err_d;

   logic [N-1:0]  sel_oh;
   logic          drain;
   logic          accept;
   logic          dest_ok;

   assign sel_oh  = N'(1) << sel_q;
   assign drain   = full_q && (|(bus.m_ready & sel_oh));
   assign dest_ok = 32'(bus.s_dest) < N;
   assign accept  = bus.s_valid && bus.s_ready;

   assign bus.m_valid = full_q ? sel_oh : '0;
   assign bus.m_data  = data_q;
   assign bus.m_last  = last_q;
   assign busy        = (state_q != IDLE) || full_q;
   assign err_dest    = err_q;

   always_comb begin
      bus.s_ready = !full_q || drain;
      if (state_q == DROP) bus.s_ready = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      full_d  = full_q;
      data_d  = data_q;
      last_d  = last_q;
      sel_d   = sel_q;
      err_d   = 1'b0;

      if (drain) full_d = 1'b0;

      if (accept) begin
         unique case (state_q)
            IDLE: begin
               if (dest_ok) begin
                  sel_d   = bus.s_dest;
                  full_d  = 1'b1;
                  data_d  = bus.s_data;
                  last_d  = bus.s_last;
                  state_d = bus.s_last ? IDLE : FWD;
               end else begin
                  err_d   = 1'b1;
                  state_d = bus.s_last ? IDLE : DROP;
               end
            end
            FWD: begin
               full_d = 1'b1;
               data_d = bus.s_data;
               last_d = bus.s_last;
               if (bus.s_last) state_d = IDLE;
            end
            DROP: begin
               if (bus.s_last) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         full_q  <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         sel_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         full_q  <= full_d;
         data_q  <= data_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
      end
   end

`ifdef DEMUX_STREAM_CTRL_CNT_EN
   // Counts packets as their last beat leaves the output register, so dropped packets never count.
   logic [15:0] cnt_q [N];
   logic [15:0] cnt_d [N];

   always_comb begin
      pkt_cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         if (drain && last_q && sel_oh[i]) cnt_d[i] = cnt_q[i] + 16'd1;
         pkt_cnt[i*16 +: 16] = cnt_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      end
   end
`endif

endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Directed bench for demux_stream_ctrl: single beats, select lock, backpressure, drop, reset.
module tb_demux_stream_ctrl;
   localparam int N  = 2;
   localparam int DW = 1;
   localparam int SW = 2;

   logic clk;
   logic rst_n;
   logic busy;
   logic err_dest;
`ifdef DEMUX_STREAM_CTRL_CNT_EN
   logic [N*16-1:0] pkt_cnt;
`endif

   int checks;
   int errors;

   demux_stream_ctrl_if #(.N(N), .DW(DW), .SW(SW)) bus ();

   demux_stream_ctrl #(.N(N), .DW(DW), .SW(SW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .busy     (busy),
      .err_dest (err_dest)
`ifdef DEMUX_STREAM_CTRL_CNT_EN
      ,
      .pkt_cnt  (pkt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [SW-1:0] dest, input logic [DW-1:0] data,
                        input logic last);
      bus.s_valid = v;
      bus.s_dest  = dest;
      bus.s_data  = data;
      bus.s_last  = last;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.m_ready = 2'b11;
      idle();
      #2;
      check("rst_m_valid", 32'(bus.m_valid), 32'h0);
      check("rst_m_data", 32'(bus.m_data), 32'h0);
      check("rst_m_last", 32'(bus.m_last), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err", 32'(err_dest), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // two single-beat packets back to back
      drive(1'b1, 2'd0, 1'b1, 1'b1);
      #1 check("t1_s_ready0", 32'(bus.s_ready), 32'h1);
      @(negedge clk);
      check("t1_m_valid0", 32'(bus.m_valid), 32'h1);
      check("t1_m_data0", 32'(bus.m_data), 32'h1);
      check("t1_m_last0", 32'(bus.m_last), 32'h1);
      drive(1'b1, 2'd1, 1'b0, 1'b1);
      #1 check("t1_s_ready1", 32'(bus.s_ready), 32'h1);
      @(negedge clk);
      check("t1_m_valid1", 32'(bus.m_valid), 32'h2);
      check("t1_m_data1", 32'(bus.m_data), 32'h0);
      idle();
      @(negedge clk);
      check("t1_drained", 32'(bus.m_valid), 32'h0);
      check("t1_busy", 32'(busy), 32'h0);

      // 3-beat packet: select locks on beat 1 despite s_dest toggling
      drive(1'b1, 2'd1, 1'b1, 1'b0);
      @(negedge clk);
      check("t2_b1_valid", 32'(bus.m_valid), 32'h2);
      check("t2_b1_last", 32'(bus.m_last), 32'h0);
      check("t2_b1_busy", 32'(busy), 32'h1);
      drive(1'b1, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      check("t2_b2_valid", 32'(bus.m_valid), 32'h2);
      check("t2_b2_data", 32'(bus.m_data), 32'h0);
      check("t2_b2_last", 32'(bus.m_last), 32'h0);
      drive(1'b1, 2'd0, 1'b1, 1'b1);
      @(negedge clk);
      check("t2_b3_valid", 32'(bus.m_valid), 32'h2);
      check("t2_b3_data", 32'(bus.m_data), 32'h1);
      check("t2_b3_last", 32'(bus.m_last), 32'h1);
      idle();
      @(negedge clk);
      check("t2_end_valid", 32'(bus.m_valid), 32'h0);
      check("t2_end_busy", 32'(busy), 32'h0);

      // backpressure on channel 0; channel 1 ready must not matter
      bus.m_ready = 2'b10;
      drive(1'b1, 2'd0, 1'b1, 1'b1);
      @(negedge clk);
      drive(1'b1, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t3_hold_s_ready", 32'(bus.s_ready), 32'h0);
         check("t3_hold_valid", 32'(bus.m_valid), 32'h1);
         check("t3_hold_data", 32'(bus.m_data), 32'h1);
         @(negedge clk);
      end
      bus.m_ready = 2'b11;
      #1 check("t3_release_s_ready", 32'(bus.s_ready), 32'h1);
      @(negedge clk);
      check("t3_next_valid", 32'(bus.m_valid), 32'h1);
      check("t3_next_data", 32'(bus.m_data), 32'h0);
      idle();
      @(negedge clk);
      check("t3_end_valid", 32'(bus.m_valid), 32'h0);

      // invalid destination: 2-beat drop, then a good single beat
      drive(1'b1, 2'd3, 1'b1, 1'b0);
      @(negedge clk);
      check("t4_err_pulse", 32'(err_dest), 32'h1);
      check("t4_b1_valid", 32'(bus.m_valid), 32'h0);
      check("t4_b1_busy", 32'(busy), 32'h1);
      drive(1'b1, 2'd0, 1'b1, 1'b1);
      #1 check("t4_drop_s_ready", 32'(bus.s_ready), 32'h1);
      @(negedge clk);
      check("t4_err_low", 32'(err_dest), 32'h0);
      check("t4_b2_valid", 32'(bus.m_valid), 32'h0);
      check("t4_b2_busy", 32'(busy), 32'h0);
      drive(1'b1, 2'd0, 1'b1, 1'b1);
      @(negedge clk);
      check("t4_good_valid", 32'(bus.m_valid), 32'h1);
      check("t4_good_data", 32'(bus.m_data), 32'h1);
      check("t4_good_err", 32'(err_dest), 32'h0);
      idle();
      @(negedge clk);
      check("t4_end_valid", 32'(bus.m_valid), 32'h0);

      // asynchronous reset between beats 1 and 2
      drive(1'b1, 2'd1, 1'b1, 1'b0);
      @(negedge clk);
      check("t5_b1_valid", 32'(bus.m_valid), 32'h2);
      idle();
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(bus.m_valid), 32'h0);
      check("t5_rst_busy", 32'(busy), 32'h0);
      check("t5_rst_err", 32'(err_dest), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_post_valid", 32'(bus.m_valid), 32'h0);
      drive(1'b1, 2'd0, 1'b0, 1'b1);
      @(negedge clk);
      check("t5_new_valid", 32'(bus.m_valid), 32'h1);
      check("t5_new_data", 32'(bus.m_data), 32'h0);
      check("t5_new_last", 32'(bus.m_last), 32'h1);
      idle();
      @(negedge clk);
      check("t5_end_busy", 32'(busy), 32'h0);

`ifdef DEMUX_STREAM_CTRL_CNT_EN
      rst_n = 1'b0;
      #1 check("t6_cnt_rst", 32'(pkt_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'd1, 1'b1, 1'b1);
         @(negedge clk);
      end
      drive(1'b1, 2'd2, 1'b1, 1'b1);
      @(negedge clk);
      idle();
      @(negedge clk);
      @(negedge clk);
      check("t6_cnt_ch1", 32'(pkt_cnt[31:16]), 32'd3);
      check("t6_cnt_ch0", 32'(pkt_cnt[15:0]), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
